// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: width and chunk-boundary helpers shared by the adder pipeline and its bench.
package add_pipe_pkg;

    function automatic int max_i(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Boundaries are clamped to WS so degenerate STAGES/WS mixes give empty chunks, never negative ones.
    function automatic int chunk_lo(input int k, input int c, input int ws);
        return (k * c < ws) ? k * c : ws;
    endfunction

    function automatic int chunk_hi(input int k, input int c, input int ws, input int stages);
        return (k == stages - 1) ? ws : chunk_lo(k + 1, c, ws);
    endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// add_pipe_stage: adds bits [HI-1:LO] of the operands with the incoming carry, registers the
// result chunk into the partial sum, carries the operands forward and holds everything when en=0.
module add_pipe_stage #(
    parameter int WS = 5,
    parameter int LO = 0,
    parameter int HI = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          prev_v,
    input  logic          prev_c,
    input  logic [WS-1:0] prev_a,
    input  logic [WS-1:0] prev_b,
    input  logic [WS-1:0] prev_s,
    output logic          v,
    output logic          c,
    output logic [WS-1:0] a,
    output logic [WS-1:0] b,
    output logic [WS-1:0] s
);
    localparam int W = HI - LO;
    localparam logic [WS:0] MASK = (WS+1)'((64'd1 << W) - 64'd1);

    logic [WS:0] t;

    // Bit W of the masked sum is the carry out of this chunk.
    assign t = (((WS+1)'(prev_a) >> LO) & MASK) + (((WS+1)'(prev_b) >> LO) & MASK) + (WS+1)'(prev_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            c <= 1'b0;
            a <= '0;
            b <= '0;
            s <= '0;
        end else if (en) begin
            v <= prev_v;
            if (prev_v) begin
                c <= t[W];
                a <= prev_a;
                b <= prev_b;
                s <= prev_s | WS'((t & MASK) << LO);
            end
        end
    end
endmodule

// File: rtl/add_pipe.sv
// add_pipe: STAGES-deep carry-chain pipelined adder with valid/ready handshakes.
// Define ADD_PIPE_SIGNED_EN to treat A and B as two's complement (sign-extended) operands.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter  int WA     = 4,
    parameter  int WB     = 3,
    parameter  int STAGES = 2,
    localparam int WS     = max_i(WA, WB) + 1,
    localparam int C      = ceil_div(WS, STAGES)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [WA-1:0] A,
    input  logic [WB-1:0] B,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [WS-1:0] SUM
);
    logic          v  [STAGES+1];
    logic          cy [STAGES+1];
    logic [WS-1:0] ap [STAGES+1];
    logic [WS-1:0] bp [STAGES+1];
    logic [WS-1:0] sp [STAGES+1];
    logic          advance;

    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;

`ifdef ADD_PIPE_SIGNED_EN
    assign ap[0] = {{(WS-WA){A[WA-1]}}, A};
    assign bp[0] = {{(WS-WB){B[WB-1]}}, B};
`else
    assign ap[0] = {{(WS-WA){1'b0}}, A};
    assign bp[0] = {{(WS-WB){1'b0}}, B};
`endif
    assign v[0]  = IN_VALID;
    assign cy[0] = 1'b0;
    assign sp[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_pipe_stage #(
            .WS(WS),
            .LO(chunk_lo(k, C, WS)),
            .HI(chunk_hi(k, C, WS, STAGES))
        ) u_stage (
            .clk(CLK),
            .rst(RST),
            .en(advance),
            .prev_v(v[k]),
            .prev_c(cy[k]),
            .prev_a(ap[k]),
            .prev_b(bp[k]),
            .prev_s(sp[k]),
            .v(v[k+1]),
            .c(cy[k+1]),
            .a(ap[k+1]),
            .b(bp[k+1]),
            .s(sp[k+1])
        );
    end

    assign OUT_VALID = v[STAGES];
    assign SUM       = sp[STAGES];
endmodule
